// File: rtl/vsram_write_sequencer.sv
// rtl/vsram_write_sequencer.sv - buffered round-robin write command sequencer for the vSRAM demux
// Optional stall input (in_stall) is enabled by defining VSRAM_SEQ_STALL_EN.
module vsram_write_sequencer #(
  parameter int DATA_W     = 48,
  parameter int COL_W      = 9,
  parameter int LEN_W      = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_start,
  input  logic [LEN_W-1:0]  in_frameLen,
  input  logic [COL_W-1:0]  in_startCol,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
`ifdef VSRAM_SEQ_STALL_EN
  input  logic              in_stall,
`endif
  output logic              in_ready,
  output logic              out_writeEnable,
  output logic [1:0]        out_vsramNum,
  output logic [COL_W-1:0]  out_colNum,
  output logic [DATA_W-1:0] out_dataWriteVal,
  output logic              busy,
  output logic              frame_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [COL_W-1:0] IDLE_COL = COL_W'(8'hff);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count, count_d;
  logic [LEN_W-1:0]  len_q, len_d, acc_cnt, acc_d, iss_cnt, iss_d;
  logic [COL_W-1:0]  base_q, base_d, col_d;
  logic              push, pop, stall, ready_d;

`ifdef VSRAM_SEQ_STALL_EN
  assign stall = in_stall;
`else
  assign stall = 1'b0;
`endif

  // Four vSRAMs per column: the column advances once every four issued words.
  assign col_d = base_q + COL_W'(iss_cnt >> 2);

  always_comb begin
    state_d = state;
    len_d   = len_q;
    base_d  = base_q;
    acc_d   = acc_cnt;
    iss_d   = iss_cnt;
    push    = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (in_start) begin
          len_d   = in_frameLen;
          base_d  = in_startCol;
          acc_d   = '0;
          iss_d   = '0;
          state_d = (in_frameLen == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        push = in_valid && in_ready;
        pop  = (count != '0) && !stall;
        if (push) acc_d = acc_cnt + LEN_W'(1);
        if (pop) begin
          iss_d = iss_cnt + LEN_W'(1);
          if (iss_cnt == len_q - LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    count_d = count + (PW+1)'(push) - (PW+1)'(pop);
    // Ready looks only at next-cycle occupancy, so a same-cycle pop never earns an extra slot.
    ready_d = (state_d == RUN) && (count_d != FULL_CNT) && (acc_d < len_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q            <= '0;
      base_q           <= '0;
      acc_cnt          <= '0;
      iss_cnt          <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      in_ready         <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      out_writeEnable  <= 1'b0;
      out_vsramNum     <= 2'd0;
      out_colNum       <= IDLE_COL;
      out_dataWriteVal <= '0;
    end else begin
      len_q            <= len_d;
      base_q           <= base_d;
      acc_cnt          <= acc_d;
      iss_cnt          <= iss_d;
      count            <= count_d;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      in_ready         <= ready_d;
      busy             <= (state_d != IDLE);
      frame_done       <= (state == DONE);
      out_writeEnable  <= pop;
      out_vsramNum     <= pop ? iss_cnt[1:0] : 2'd0;
      out_colNum       <= pop ? col_d : IDLE_COL;
      out_dataWriteVal <= pop ? mem[rd_ptr] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_vsram_write_sequencer.sv
// tb/tb_vsram_write_sequencer.sv - self-checking bench for vsram_write_sequencer
// Scoreboard derives each write from the accepted-word queue and the frame's base column.
module tb_vsram_write_sequencer;
  localparam int DATA_W = 48;
  localparam int COL_W  = 9;
  localparam int LEN_W  = 11;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_start = 1'b0;
  logic [LEN_W-1:0]  in_frameLen = '0;
  logic [COL_W-1:0]  in_startCol = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
`ifdef VSRAM_SEQ_STALL_EN
  logic              in_stall = 1'b0;
`endif
  logic              in_ready, out_writeEnable, busy, frame_done;
  logic [1:0]        out_vsramNum;
  logic [COL_W-1:0]  out_colNum;
  logic [DATA_W-1:0] out_dataWriteVal;

  vsram_write_sequencer dut (
    .clock(clock), .reset(reset), .in_start(in_start),
    .in_frameLen(in_frameLen), .in_startCol(in_startCol),
    .in_valid(in_valid), .in_data(in_data),
`ifdef VSRAM_SEQ_STALL_EN
    .in_stall(in_stall),
`endif
    .in_ready(in_ready), .out_writeEnable(out_writeEnable),
    .out_vsramNum(out_vsramNum), .out_colNum(out_colNum),
    .out_dataWriteVal(out_dataWriteVal), .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int len; int col; int prob; int seq;
    int exp_writes; int exp_last_col; int exp_last_vsram;
  } vec_t;
  vec_t tbl[7];

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int m_len = 0, m_col = 0, wr_idx = 0;
  logic [DATA_W-1:0] acc_q[$];
  bit expect_done = 0, done_seen = 0, lat_chk = 1;
  int first_push_cyc = 0, last_wr_cyc = 0, start_cyc = 0;
  int last_col = 0, last_vsram = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    if (in_valid && in_ready && !reset) begin
      if (acc_q.size() == 0) first_push_cyc = cyc + 1;
      acc_q.push_back(in_data);
    end
    @(posedge clock); #1;
    cyc++;
    if (out_writeEnable) begin
      check("extra_write", 64'(wr_idx < m_len && wr_idx < acc_q.size()), 64'd1);
      if (wr_idx < acc_q.size()) begin
        check("wr_vsram", out_vsramNum, wr_idx % 4);
        check("wr_col", out_colNum, (m_col + wr_idx / 4) % 512);
        check("wr_data", out_dataWriteVal, acc_q[wr_idx]);
        if (wr_idx == 0 && lat_chk) check("first_write_latency", cyc - first_push_cyc, 1);
      end
      last_col = out_colNum; last_vsram = out_vsramNum; last_wr_cyc = cyc;
      wr_idx++;
    end else begin
      check("idle_cmd", {out_colNum, out_dataWriteVal}, {9'h0ff, 48'h0});
    end
    if (frame_done) begin
      check("done_expected", expect_done, 1);
      if (expect_done) begin
        check("frame_writes", wr_idx, m_len);
        check("frame_pushes", acc_q.size(), m_len);
        if (m_len == 0) check("zero_len_done_delay", cyc - start_cyc, 2);
        else            check("done_after_last_write", cyc - last_wr_cyc, 1);
      end
      expect_done = 0;
      done_seen = 1;
    end else if (expect_done && acc_q.size() == m_len) begin
      check("ready_after_len", in_ready, 0);
    end
  endtask

  task automatic start_frame(int len, int col);
    in_start = 1; in_frameLen = LEN_W'(len); in_startCol = COL_W'(col);
    m_len = len; m_col = col; acc_q.delete(); wr_idx = 0;
    expect_done = 1; done_seen = 0; start_cyc = cyc;
    tick();
    in_start = 0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_frame(int len, int col, int prob, int seq, bit poke);
    start_frame(len, col);
    for (int i = 0; i < 20 * len + 20 && !done_seen; i++) begin
      in_valid = ($urandom_range(99) < prob);
      in_data  = seq != 0 ? DATA_W'(acc_q.size() + 1) : DATA_W'({$urandom(), $urandom()});
      if (poke && i == 2) begin
        in_start = 1; in_frameLen = LEN_W'(2); in_startCol = COL_W'(77);
      end else in_start = 0;
      tick();
    end
    in_valid = 0; in_start = 0;
    check("frame_timeout", done_seen, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            len   col  prob seq writes last_col last_vsram
    tbl[0] = '{   8,    5, 100,  1,    8,      6,     3};
    tbl[1] = '{   8,  511, 100,  0,    8,      0,     3};
    tbl[2] = '{   1,  100,  50,  0,    1,    100,     0};
    tbl[3] = '{   5,  510,  70,  0,    5,    511,     0};
    tbl[4] = '{  13,  511,  40,  0,   13,      2,     0};
    tbl[5] = '{   3,    0, 100,  0,    3,      0,     2};
    tbl[6] = '{2047,  300, 100,  0, 2047,    299,     2};

    repeat (3) @(posedge clock);
    #1;
    check("rst_we", out_writeEnable, 0);
    check("rst_col", out_colNum, 9'h0ff);
    check("rst_data", out_dataWriteVal, 0);
    check("rst_vsram", out_vsramNum, 0);
    check("rst_flags", {in_ready, busy, frame_done}, 3'b000);
    reset = 0;
    tick();
    check("idle_ready", in_ready, 0);

    for (int t = 0; t < 7; t++) begin
      run_frame(tbl[t].len, tbl[t].col, tbl[t].prob, tbl[t].seq, 1'b0);
      check("tbl_writes", wr_idx, tbl[t].exp_writes);
      check("tbl_last_col", last_col, tbl[t].exp_last_col);
      check("tbl_last_vsram", last_vsram, tbl[t].exp_last_vsram);
      check("tbl_idle_ready", in_ready, 0);
      tick();
    end

    run_frame(0, 9, 100, 0, 1'b0);
    check("zero_len_writes", wr_idx, 0);
    tick();

    for (int r = 0; r < 6; r++) begin
      run_frame($urandom_range(10, 40), $urandom_range(0, 511), $urandom_range(30, 100), 0, 1'b1);
      tick();
    end

`ifdef VSRAM_SEQ_STALL_EN
    lat_chk = 0;
    in_stall = 1;
    start_frame(6, 40);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_data = DATA_W'({$urandom(), $urandom()});
      tick();
    end
    check("stall_pushes", acc_q.size(), 4);
    check("stall_ready", in_ready, 0);
    check("stall_writes", wr_idx, 0);
    in_stall = 0;
    for (int i = 0; i < 60 && !done_seen; i++) begin
      in_data = DATA_W'({$urandom(), $urandom()});
      tick();
    end
    in_valid = 0;
    check("stall_frame_done", done_seen, 1);
    lat_chk = 1;
    tick();
`endif

    start_frame(5, 20);
    for (int i = 0; i < 40 && wr_idx < 2; i++) begin
      in_valid = 1; in_data = DATA_W'({$urandom(), $urandom()});
      tick();
    end
    in_valid = 0;
    check("midreset_two_writes", wr_idx, 2);
    #3 reset = 1;
    #1;
    check("async_rst_we", out_writeEnable, 0);
    check("async_rst_col", out_colNum, 9'h0ff);
    check("async_rst_data", out_dataWriteVal, 0);
    check("async_rst_flags", {in_ready, busy, frame_done}, 3'b000);
    acc_q.delete(); m_len = 0; wr_idx = 0; expect_done = 0;
    repeat (3) tick();
    reset = 0;
    for (int i = 0; i < 12; i++) tick();
    check("post_reset_writes", wr_idx, 0);
    check("post_reset_flags", {in_ready, busy}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
